// File: rtl/id_token_stats.sv
// Token statistics for the identifier-recognizer match flag: counts runs of
// high samples and tracks their lengths. Define ID_STATS_SAT_EN for saturating counters.
module id_token_stats #(
  parameter int CNT_W    = 8,
  parameter int LEN_W    = 6,
  parameter int LONG_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             match,
  input  logic             clr,
  output logic [CNT_W-1:0] tok_cnt,
  output logic [CNT_W-1:0] long_cnt,
  output logic [LEN_W-1:0] last_len,
  output logic [LEN_W-1:0] max_len,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_SKIP = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] run_len_q, run_len_d;
  logic [CNT_W-1:0] tok_cnt_q, tok_cnt_d;
  logic [CNT_W-1:0] long_cnt_q, long_cnt_d;
  logic [LEN_W-1:0] last_len_q, last_len_d;
  logic [LEN_W-1:0] max_len_q, max_len_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef ID_STATS_SAT_EN
    return (&v) ? v : v + 1'b1;
`else
    return v + 1'b1;
`endif
  endfunction

  always_comb begin
    state_d    = state_q;
    run_len_d  = run_len_q;
    tok_cnt_d  = tok_cnt_q;
    long_cnt_d = long_cnt_q;
    last_len_d = last_len_q;
    max_len_d  = max_len_q;
    done_d     = 1'b0;
    if (clr) begin
      // A run cut by clr is discarded; the remaining high samples are skipped.
      state_d    = match ? S_SKIP : S_IDLE;
      run_len_d  = '0;
      tok_cnt_d  = '0;
      long_cnt_d = '0;
      last_len_d = '0;
      max_len_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (match) begin
            state_d   = S_RUN;
            tok_cnt_d = cnt_inc(tok_cnt_q);
            run_len_d = LEN_W'(1);
          end
        end
        S_RUN: begin
          if (match) begin
            run_len_d = len_inc(run_len_q);
          end else begin
            state_d    = S_IDLE;
            last_len_d = run_len_q;
            done_d     = 1'b1;
            if (run_len_q > max_len_q) max_len_d = run_len_q;
            if (run_len_q >= LEN_W'(LONG_LEN)) long_cnt_d = cnt_inc(long_cnt_q);
          end
        end
        S_SKIP: begin
          if (!match) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      run_len_q  <= '0;
      tok_cnt_q  <= '0;
      long_cnt_q <= '0;
      last_len_q <= '0;
      max_len_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_len_q  <= run_len_d;
      tok_cnt_q  <= tok_cnt_d;
      long_cnt_q <= long_cnt_d;
      last_len_q <= last_len_d;
      max_len_q  <= max_len_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tok_cnt  = tok_cnt_q;
  assign long_cnt = long_cnt_q;
  assign last_len = last_len_q;
  assign max_len  = max_len_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_id_token_stats.sv
// Scoreboard bench for id_token_stats: expected stats are queued when a run
// is terminated, and a monitor compares them on every done pulse.
module tb_id_token_stats;

  logic       clk;
  logic       reset;
  logic       match;
  logic       clr;
  logic [7:0] tok_cnt;
  logic [7:0] long_cnt;
  logic [5:0] last_len;
  logic [5:0] max_len;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic [7:0] tok;
    logic [7:0] lng;
    logic [5:0] last;
    logic [5:0] mx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  id_token_stats #(.CNT_W(8), .LEN_W(6), .LONG_LEN(4)) dut (
    .clk(clk), .reset(reset), .match(match), .clr(clr),
    .tok_cnt(tok_cnt), .long_cnt(long_cnt), .last_len(last_len),
    .max_len(max_len), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic tick(input logic m, input logic c);
    match = m;
    clr   = c;
    @(negedge clk);
  endtask

  task automatic push(input int t, input int l, input int la, input int mx);
    exp_t e;
    e.tok  = 8'(t);
    e.lng  = 8'(l);
    e.last = 6'(la);
    e.mx   = 6'(mx);
    exp_q.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tok"},  tok_cnt,  0);
    chk({tag, "_long"}, long_cnt, 0);
    chk({tag, "_last"}, last_len, 0);
    chk({tag, "_max"},  max_len,  0);
    chk({tag, "_busy"}, busy,     0);
    chk({tag, "_done"}, done,     0);
  endtask

  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 tok=%0d last=%0d", tok_cnt, last_len);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_tok",  tok_cnt,  e.tok);
        chk("mon_long", long_cnt, e.lng);
        chk("mon_last", last_len, e.last);
        chk("mon_max",  max_len,  e.mx);
      end
    end
  end

  initial begin
    int exp_tok;
    reset = 1'b1;
    match = 1'b0;
    clr   = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;

    // Test 1: single run of 3
    tick(0, 0);
    tick(1, 0);
    chk("t1_tok", tok_cnt, 1);
    chk("t1_busy1", busy, 1);
    tick(1, 0);
    chk("t1_busy2", busy, 1);
    tick(1, 0);
    chk("t1_busy3", busy, 1);
    push(1, 0, 3, 3);
    tick(0, 0);
    chk("t1_busy_end", busy, 0);
    tick(0, 0);
    chk("t1_done_once", done, 0);

    // Test 2: runs of 2, 5, 1
    tick(0, 1);
    chk_zero("t2_clr");
    tick(1, 0); tick(1, 0);
    push(1, 0, 2, 2);
    tick(0, 0);
    repeat (5) tick(1, 0);
    push(2, 1, 5, 5);
    tick(0, 0);
    tick(1, 0);
    push(3, 1, 1, 5);
    tick(0, 0);
    tick(0, 0);
    chk("t2_tok", tok_cnt, 3);
    chk("t2_long", long_cnt, 1);
    chk("t2_max", max_len, 5);
    chk("t2_last", last_len, 1);

    // Test 3: clear mid-run, then skip the rest of that run
    tick(1, 0);
    chk("t3_tok_pre", tok_cnt, 4);
    tick(1, 1);
    chk_zero("t3_clr");
    tick(1, 0);
    tick(1, 0);
    chk("t3_skip_busy", busy, 0);
    chk("t3_skip_tok", tok_cnt, 0);
    tick(0, 0);
    chk("t3_skip_done", done, 0);
    tick(1, 0); tick(1, 0);
    push(1, 0, 2, 2);
    tick(0, 0);
    tick(0, 0);
    chk("t3_tok", tok_cnt, 1);
    chk("t3_last", last_len, 2);

    // Test 4: asynchronous reset mid-run
    tick(1, 0); tick(1, 0);
    #2 reset = 1'b1;
    #1 chk_zero("t4_async");
    @(negedge clk);
    reset = 1'b0;
    tick(1, 0);
    chk("t4_tok", tok_cnt, 1);
    chk("t4_busy", busy, 1);
    push(1, 0, 1, 1);
    tick(0, 0);
    tick(0, 0);

    // Test 5: 256 single-sample runs
    tick(0, 1);
    for (int i = 0; i < 256; i++) begin
`ifdef ID_STATS_SAT_EN
      exp_tok = (i + 1 > 255) ? 255 : i + 1;
`else
      exp_tok = (i + 1) % 256;
`endif
      tick(1, 0);
      push(exp_tok, 0, 1, 1);
      tick(0, 0);
    end
    tick(0, 0);
`ifdef ID_STATS_SAT_EN
    chk("t5_tok_sat", tok_cnt, 255);
`else
    chk("t5_tok_wrap", tok_cnt, 0);
`endif

    // Test 6: 70-sample run saturates run length at 63
    tick(0, 1);
    repeat (70) tick(1, 0);
    chk("t6_busy", busy, 1);
    push(1, 1, 63, 63);
    tick(0, 0);
    tick(0, 0);
    chk("t6_last", last_len, 63);
    chk("t6_max", max_len, 63);
    chk("t6_long", long_cnt, 1);

    tick(0, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
